switch_debouncer: RTL and testbench

Conditions a raw, bouncing, asynchronous switch or push-button signal into a clean, single-clock-domain level. It drives the `D` input of the downstream `d_ff` storage stage and optionally provides one-cycle rising and falling edge pulses. The block contains a multi-flop synchroniser, a stability counter and a four-state FSM. A new output level is committed only after the synchronised input has held its new value for `STABLE_CYCLES` consecutive clocks.

---
 rtl/switch_debouncer_pkg.sv | 15 +
 rtl/sync_chain.sv | 29 ++
 rtl/switch_debouncer.sv | 131 +++++++++++++
 tb/tb_switch_debouncer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared types and default constants for the switch debouncer and its synchroniser.
package switch_debouncer_pkg;

  localparam int unsigned DB_N_SYNC        = 2;
  localparam int unsigned DB_STABLE_CYCLES = 50000;
  localparam int unsigned DB_CNT_W         = 16;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } db_state_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous input; last flop is the safe sample.
module sync_chain
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned N_SYNC = DB_N_SYNC
) (
  input  logic CLK,
  input  logic Reset,
  input  logic raw,
  output logic sync_q
);

  logic [N_SYNC-1:0] chain;

  if (N_SYNC < 2) begin : g_chk_n_sync
    $error("sync_chain: N_SYNC must be at least 2");
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[N_SYNC-2:0], raw};
    end
  end

  assign sync_q = chain[N_SYNC-1];

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a raw switch into a registered level once the synchronised input holds for STABLE_CYCLES clocks.
// Define SWITCH_DEBOUNCER_EDGE_EN to add registered one-cycle RISE/FALL pulses.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned N_SYNC        = DB_N_SYNC,
  parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DB_CNT_W
) (
  input  logic CLK,
  input  logic Reset,
  input  logic SW_in,
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  output logic RISE,
  output logic FALL,
`endif
  output logic SW_clean
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               DIRECT   = (STABLE_CYCLES == 1);

  if (STABLE_CYCLES < 1) begin : g_chk_stable
    $error("switch_debouncer: STABLE_CYCLES must be at least 1");
  end
  if ((64'(1) << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_chk_cnt_w
    $error("switch_debouncer: CNT_W too narrow for STABLE_CYCLES");
  end

  logic             sync_q;
  db_state_t        state;
  db_state_t        next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             clean_d;

  sync_chain #(
    .N_SYNC (N_SYNC)
  ) u_sync (
    .CLK    (CLK),
    .Reset  (Reset),
    .raw    (SW_in),
    .sync_q (sync_q)
  );

  // Next-state and counter; the counter only runs in CHK states and stops at CNT_LAST.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_LO: begin
        if (sync_q) begin
          if (DIRECT) begin
            next_state = ST_HI;
            next_cnt   = '0;
          end else begin
            next_state = CHK_HI;
            next_cnt   = CNT_ONE;
          end
        end
      end
      CHK_HI: begin
        if (!sync_q) begin
          next_state = ST_LO;
          next_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = ST_HI;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!sync_q) begin
          if (DIRECT) begin
            next_state = ST_LO;
            next_cnt   = '0;
          end else begin
            next_state = CHK_LO;
            next_cnt   = CNT_ONE;
          end
        end
      end
      CHK_LO: begin
        if (sync_q) begin
          next_state = ST_HI;
          next_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = ST_LO;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      default: begin
        next_state = ST_LO;
        next_cnt   = '0;
      end
    endcase
  end

  // Clean level is a decode of the upcoming state, registered alongside it.
  assign clean_d = (next_state == ST_HI) || (next_state == CHK_LO);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= ST_LO;
      cnt      <= '0;
      SW_clean <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      SW_clean <= clean_d;
    end
  end

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  // SW_clean only changes on a commit, so its registered transition is the commit pulse.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      RISE <= 1'b0;
      FALL <= 1'b0;
    end else begin
      RISE <= ~SW_clean & clean_d;
      FALL <= SW_clean & ~clean_d;
    end
  end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: reset, clean edges, bounce, glitch, reset mid-count, minimum window.
module tb_switch_debouncer;
  import switch_debouncer_pkg::*;

  logic CLK = 1'b0;
  logic Reset;
  logic sw_in;
  logic sw_clean;
  logic sw_in_min;
  logic sw_clean_min;
  logic q_min;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic rise;
  logic fall;
  logic rise_min;
  logic fall_min;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  switch_debouncer #(
    .N_SYNC        (2),
    .STABLE_CYCLES (4),
    .CNT_W         (3)
  ) u_dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .SW_in    (sw_in),
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    .RISE     (rise),
    .FALL     (fall),
`endif
    .SW_clean (sw_clean)
  );

  switch_debouncer #(
    .N_SYNC        (2),
    .STABLE_CYCLES (1),
    .CNT_W         (1)
  ) u_min (
    .CLK      (CLK),
    .Reset    (Reset),
    .SW_in    (sw_in_min),
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    .RISE     (rise_min),
    .FALL     (fall_min),
`endif
    .SW_clean (sw_clean_min)
  );

  // Downstream d_ff storage stage fed by the debounced level.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) q_min <= 1'b0;
    else       q_min <= sw_clean_min;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic exp_clean, input logic exp_rise,
                         input logic exp_fall);
    check({tag, "_clean"}, 32'(sw_clean), 32'(exp_clean));
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    check({tag, "_rise"}, 32'(rise), 32'(exp_rise));
    check({tag, "_fall"}, 32'(fall), 32'(exp_fall));
`else
    if (exp_rise === 1'bx || exp_fall === 1'bx) $display("note: unexpected x in %s", tag);
`endif
  endtask

  initial begin
    logic [6:0] bounce_pat;
    bounce_pat = 7'b1111011;

    Reset     = 1'b1;
    sw_in     = 1'b0;
    sw_in_min = 1'b0;
    tick();
    tick();
    chk_out("reset_hold", 1'b0, 1'b0, 1'b0);
    check("reset_state", 32'(u_dut.state), 32'(ST_LO));
    Reset = 1'b0;

    // Clean rise: commit on edge 5 after first capture.
    sw_in = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      chk_out($sformatf("rise_e%0d", e), e >= 5, e == 5, 1'b0);
    end

    // Clean fall.
    sw_in = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      chk_out($sformatf("fall_e%0d", e), e < 5, 1'b0, e == 5);
    end

    // Three-cycle glitch never reaches the output.
    for (int e = 0; e <= 9; e++) begin
      sw_in = (e < 3);
      tick();
      chk_out($sformatf("glitch_e%0d", e), 1'b0, 1'b0, 1'b0);
      if (e == 4) check("glitch_in_window", 32'(u_dut.state), 32'(CHK_HI));
    end
    check("glitch_state", 32'(u_dut.state), 32'(ST_LO));

    // Bounce 1,1,0,1,1,1,1: window restarts, commit on edge 8.
    for (int e = 0; e <= 9; e++) begin
      sw_in = (e < 7) ? bounce_pat[e] : 1'b1;
      tick();
      chk_out($sformatf("bounce_e%0d", e), e >= 8, e == 8, 1'b0);
    end
    check("bounce_state", 32'(u_dut.state), 32'(ST_HI));

    // Falling transition interrupted by an asynchronous reset before edge 3.
    sw_in = 1'b0;
    for (int e = 0; e <= 2; e++) begin
      tick();
      chk_out($sformatf("rstfall_e%0d", e), 1'b1, 1'b0, 1'b0);
    end
    Reset = 1'b1;
    #1;
    chk_out("async_reset", 1'b0, 1'b0, 1'b0);
    check("async_reset_state", 32'(u_dut.state), 32'(ST_LO));
    tick();
    Reset = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      chk_out($sformatf("post_reset_e%0d", e), 1'b0, 1'b0, 1'b0);
    end
    check("post_reset_state", 32'(u_dut.state), 32'(ST_LO));

    // Minimum window: commit on edge 2, d_ff output one clock later.
    sw_in_min = 1'b1;
    for (int e = 0; e <= 3; e++) begin
      tick();
      check($sformatf("min_clean_e%0d", e), 32'(sw_clean_min), 32'(e >= 2));
      check($sformatf("min_q_e%0d", e), 32'(q_min), 32'(e >= 3));
`ifdef SWITCH_DEBOUNCER_EDGE_EN
      check($sformatf("min_rise_e%0d", e), 32'(rise_min), 32'(e == 2));
      check($sformatf("min_fall_e%0d", e), 32'(fall_min), 32'(0));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
